// File: rtl/des_key_schedule.sv
// des_key_schedule: iterative DES subkey generator, one 48-bit subkey per handshake, encrypt or decrypt order
module des_key_schedule #(
  parameter int NUM_ROUNDS = 16,
  parameter int SUBKEY_W = 48
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                decrypt,
  input  logic [63:0]         key_in,
  output logic [SUBKEY_W-1:0] sub_key,
  output logic                sub_key_valid,
  input  logic                sub_key_ready,
  output logic [3:0]          round_idx,
  output logic                busy,
  output logic                done
);
  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;
  // Tables use FIPS numbering: position 1 is the MSB of the source vector
  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // Rounds (0-based) whose rotation is a single bit: K1, K2, K9, K16
  localparam logic [15:0] SINGLE = 16'h8103;
  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[55 - i] = k[6'(64 - PC1_T[i])];
    return r;
  endfunction
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[47 - i] = cd[6'(56 - PC2_T[i])];
    return r;
  endfunction
  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction
  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction
  state_t      state;
  logic [27:0] c, d;
  logic        dec_q;
  logic [55:0] pk;
  logic [3:0]  nxt_idx;
  logic        two, last;
  // Encrypt rotates by the shift of the round about to be emitted; decrypt undoes the one just emitted
  always_comb begin
    pk = pc1(key_in);
    nxt_idx = dec_q ? round_idx - 4'd1 : round_idx + 4'd1;
    two = dec_q ? ~SINGLE[round_idx] : ~SINGLE[nxt_idx];
    last = dec_q ? round_idx == 4'd0 : round_idx == LAST_IDX;
  end
  assign sub_key = SUBKEY_W'(pc2({c, d}));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      c <= '0;
      d <= '0;
      dec_q <= 1'b0;
      round_idx <= '0;
      sub_key_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          c <= decrypt ? pk[55:28] : rotl(pk[55:28], 1'b0);
          d <= decrypt ? pk[27:0] : rotl(pk[27:0], 1'b0);
          dec_q <= decrypt;
          round_idx <= decrypt ? LAST_IDX : 4'd0;
          sub_key_valid <= 1'b1;
          busy <= 1'b1;
          state <= S_EMIT;
        end
        S_EMIT: if (sub_key_ready) begin
          if (last) begin
            sub_key_valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
            state <= S_DONE;
          end else begin
            c <= dec_q ? rotr(c, two) : rotl(c, two);
            d <= dec_q ? rotr(d, two) : rotl(d, two);
            round_idx <= nxt_idx;
          end
        end
        default: begin
          done <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: scoreboard bench for the DES key schedule against published subkeys of 133457799BBCDFF1
module tb_des_key_schedule;
  typedef struct packed {logic [3:0] idx; logic [47:0] k;} exp_t;
  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] ALT = 64'h0123456789ABCDEF;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, decrypt = 1'b0, sub_key_ready = 1'b0;
  logic [63:0] key_in = '0;
  logic [47:0] sub_key;
  logic        sub_key_valid, busy, done;
  logic [3:0]  round_idx;
  logic [47:0] kt [16] = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
                           48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
                           48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
                           48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
  exp_t        sb [$];
  exp_t        e;
  int          tests = 0, fails = 0, hs = 0, dn;
  logic        held_v = 1'b0;
  logic [51:0] held = '0;

  des_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .key_in(key_in),
    .sub_key(sub_key), .sub_key_valid(sub_key_valid), .sub_key_ready(sub_key_ready),
    .round_idx(round_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && held_v && sub_key_valid) check("hold", {round_idx, sub_key}, held);
    if (rst_n && sub_key_valid && sub_key_ready) begin
      hs++;
      if (sb.size() == 0) check("sb_underflow", 64'(hs), 64'd0);
      else begin
        e = sb.pop_front();
        check("sub_key", sub_key, e.k);
        check("round_idx", round_idx, e.idx);
      end
    end
    held_v = rst_n && sub_key_valid && !sub_key_ready;
    held = {round_idx, sub_key};
  end

  task automatic pulse_start(input logic [63:0] key, input logic dec);
    hs = 0;
    key_in = key;
    decrypt = dec;
    start = 1'b1;
    for (int i = 0; i < 16; i++)
      sb.push_back(dec ? exp_t'({4'(15 - i), kt[15 - i]}) : exp_t'({4'(i), kt[i]}));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_to_done(input bit rnd, input int start_at, output int dn_cyc);
    dn_cyc = -1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      sub_key_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == start_at) begin
        start = 1'b1;
        key_in = ALT;
        decrypt = ~decrypt;
      end
      @(negedge clk);
      if (cyc == 1) begin
        check("first_valid", sub_key_valid, 1);
        check("first_busy", busy, 1);
      end
      if (done) begin
        dn_cyc = cyc;
        check("done_busy", busy, 0);
        check("done_valid", sub_key_valid, 0);
        break;
      end
      @(posedge clk);
      #1 start = 1'b0;
    end
    check("done_seen", 64'(dn_cyc > 0), 1);
    @(posedge clk);
    #1 sub_key_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("sb_drained", sb.size(), 0);
    check("handshakes", hs, 16);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", sub_key_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_idx", round_idx, 0);
    check("rst_key", sub_key, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // encrypt, Ready held high
    pulse_start(KEY, 1'b0);
    run_to_done(1'b0, 0, dn);
    check("t1_done_cycle", dn, 17);
    // decrypt, with a Start colliding with the final accept
    pulse_start(KEY, 1'b1);
    run_to_done(1'b0, 16, dn);
    check("t2_done_cycle", dn, 17);
    // random back-pressure
    pulse_start(KEY, 1'b0);
    run_to_done(1'b1, 0, dn);
    // Start mid-run with another key must be ignored
    pulse_start(KEY, 1'b0);
    run_to_done(1'b0, 5, dn);
    check("t4_done_cycle", dn, 17);
    // asynchronous reset mid-run
    pulse_start(KEY, 1'b0);
    sub_key_ready = 1'b1;
    for (int i = 0; i < 40 && round_idx != 4'd7; i++) @(negedge clk);
    check("t5_reach", round_idx, 7);
    #2 rst_n = 1'b0;
    #1;
    check("t5_valid", sub_key_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_idx", round_idx, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    sub_key_ready = 1'b0;
    sb.delete();
    repeat (3) begin
      @(negedge clk);
      check("t5_no_done", done, 0);
    end
    pulse_start(KEY, 1'b0);
    run_to_done(1'b0, 0, dn);
    check("t5_done_cycle", dn, 17);
    // parity bits do not affect the schedule
    pulse_start(KEY ^ 64'h0101010101010101, 1'b0);
    run_to_done(1'b0, 0, dn);
    check("t6_done_cycle", dn, 17);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
